// File: rtl/mix_columns_seq.sv
// Column-serial AES MixColumns / InvMixColumns stage with per-block bypass.
// Latency: 4 cycles from accept to out_valid; one column per cycle through a shared datapath.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready.
module mix_columns_seq #(
  parameter bit INVERSE = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic [127:0] work_q, work_d;
  logic [127:0] res_q, res_d;
  logic         byp_q, byp_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;

  logic [31:0]  col_in;
  logic [31:0]  col_out;

  // GF(2^8) doubling with reduction polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul2(input logic [7:0] x);
    return xtime(x);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ x;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
  endfunction

  // Forward matrix rows: 02 03 01 01, rotated per output row. Row 0 is the top byte.
  function automatic logic [31:0] fwd_mix(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {mul2(a0) ^ mul3(a1) ^ a2 ^ a3,
            mul2(a1) ^ mul3(a2) ^ a3 ^ a0,
            mul2(a2) ^ mul3(a3) ^ a0 ^ a1,
            mul2(a3) ^ mul3(a0) ^ a1 ^ a2};
  endfunction

  // Inverse matrix rows: 0e 0b 0d 09, rotated per output row.
  function automatic logic [31:0] inv_mix(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3),
            mule(a1) ^ mulb(a2) ^ muld(a3) ^ mul9(a0),
            mule(a2) ^ mulb(a3) ^ muld(a0) ^ mul9(a1),
            mule(a3) ^ mulb(a0) ^ muld(a1) ^ mul9(a2)};
  endfunction

  // Column datapath: select column col from the work register, then mix or pass it through.
  always_comb begin
    col_in = work_q[127:96];
    case (col_q)
      2'd0: col_in = work_q[127:96];
      2'd1: col_in = work_q[95:64];
      2'd2: col_in = work_q[63:32];
      2'd3: col_in = work_q[31:0];
      default: col_in = work_q[127:96];
    endcase
    if (byp_q) begin
      col_out = col_in;
    end else if (INVERSE) begin
      col_out = inv_mix(col_in);
    end else begin
      col_out = fwd_mix(col_in);
    end
  end

  // Next-state logic: handshake FSM, column sequencing and result write-back.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    work_d  = work_q;
    res_d   = res_q;
    byp_d   = byp_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          byp_d   = in_bypass;
          col_d   = 2'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        case (col_q)
          2'd0: res_d[127:96] = col_out;
          2'd1: res_d[95:64]  = col_out;
          2'd2: res_d[63:32]  = col_out;
          2'd3: res_d[31:0]   = col_out;
          default: res_d[127:96] = col_out;
        endcase
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Handshake outputs follow the next state so they are flops, not input-driven logic.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State registers with synchronous reset; a reset discards any in-flight or pending block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= 2'd0;
      work_q      <= 128'h0;
      res_q       <= 128'h0;
      byp_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      work_q      <= work_d;
      res_q       <= res_d;
      byp_q       <= byp_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = res_q;

endmodule
